adc_tdm_rx: RTL
===============

ADC_TDM_RX -- requirements
Module: adc_tdm_rx

Interface
REQ-001 The block SHALL have parameter BICK_DIV, default 1, meaning clk cycles per BICK half-period (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, system clock (12 MHz).
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port sdout, input, 1, codec TDM serial data, MSB-first.
REQ-005 The block SHALL have port bick, output, 1, generated codec bit clock.
REQ-006 The block SHALL have port lrck, output, 1, generated frame clock, 50% duty.
REQ-007 The block SHALL have port sample_clk, output, 1, frame-rate clock for the calibration stage, identical to lrck.
REQ-008 The block SHALL have ports adc_in0..adc_in3, output, 16 each, signed raw channel samples.
REQ-009 The block SHALL have port sample_valid, output, 1, one-clk pulse when adc_in0..3 update.

Function
REQ-010 The block SHALL run a divider counter 0..BICK_DIV-1, toggling bick when the counter wraps.
REQ-011 The block SHALL maintain a 7-bit bit counter bit_cnt, incremented on every bick falling toggle, wrapping 127->0.
REQ-012 The block SHALL decode slot = bit_cnt[6:5] and bit position p = bit_cnt[4:0] (4 slots x 32 BICK = TDM128).
REQ-013 The block SHALL drive lrck (and sample_clk) high while bit_cnt is 0..63 and low while bit_cnt is 64..127, registered in the same clk as the bit_cnt update.
REQ-014 The block SHALL sample sdout in the clk cycle in which bick toggles high (rising edge); no synchronizer, sdout is launched by the codec on bick falling.
REQ-015 The block SHALL shift sampled bits with p = 1..16 into a 16-bit shifter, MSB at p=1, LSB at p=16; bits at p=0 and p=17..31 SHALL be ignored.
REQ-016 On the rising-edge sample with p=16, the block SHALL write the completed word (including that bit) into hold register hold[slot].
REQ-017 On the rising-edge sample with bit_cnt=127, the block SHALL copy hold[0..3] to adc_in0..3 in the next clk and assert sample_valid for exactly that one clk.
REQ-018 adc_in0..3 SHALL hold their values between updates; each output updates exactly once per 128-BICK frame.
REQ-019 Output update SHALL precede sample_clk rising by BICK_DIV clk cycles minus one cycle of register delay, i.e. outputs stable at least 1 clk before sample_clk rises (for BICK_DIV=1, update and rise are 1 clk apart).
REQ-020 Frame period SHALL be 256*BICK_DIV clk cycles (BICK_DIV=1: 256 clk, 46.875 kHz at 12 MHz).
REQ-021 sdout values SHALL be passed through as two's-complement without scaling, clamping or sign manipulation.

Reset
REQ-022 While rst_n is low, all registers SHALL clear asynchronously: bick=0, lrck=0, sample_clk=0, bit_cnt=127, divider=0, shifter=0, hold[0..3]=0, adc_in0..3=0, sample_valid=0.
REQ-023 After rst_n deasserts, the first bick falling toggle SHALL move bit_cnt 127->0 and raise lrck, starting a complete frame; the first sample_valid SHALL occur at the end of that frame.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; no sample_valid SHALL be produced for it.

Verification
REQ-025 BICK_DIV=1, codec model drives slots 0..3 = 0x1234, 0x8000, 0x7FFF, 0xFFFF -> after frame end adc_in0..3 = 4660, -32768, 32767, -1 with a single sample_valid pulse.
REQ-026 BICK_DIV=1, free-run 10 frames -> sample_valid pulses exactly 256 clk apart, lrck high 128 clk and low 128 clk per frame, bick period 2 clk.
REQ-027 Codec drives 1s at p=0 and p=17..31 of every slot, data 0x0000 -> all adc_in = 0.
REQ-028 BICK_DIV=3 -> bick period 6 clk, frame 768 clk, samples 0x00FF/0xFF00/0x0001/0x8001 reproduced exactly.
REQ-029 rst_n pulsed low at bit_cnt=70 after one valid frame -> outputs read 0 immediately, no sample_valid for the interrupted frame, next full frame delivers correct values.
REQ-030 Outputs checked stable from sample_valid through the next sample_clk rising edge, with at least 1 clk of setup before that edge for BICK_DIV=1 and 3.

Source files
------------

// File: rtl/adc_tdm_rx_if.sv
// adc_tdm_rx_if
// Bundles the codec-facing serial pins and the parallel sample outputs of the
// TDM128 ADC receiver.
//   sdout        : codec serial data, MSB-first (into the receiver)
//   bick         : generated bit clock (out of the receiver)
//   lrck         : generated frame clock, 50% duty (out of the receiver)
//   sample_clk   : frame-rate clock for the calibration stage, equal to lrck
//   adc_in0..3   : signed raw samples, one per TDM slot
//   sample_valid : one-clk pulse when adc_in0..3 update
// Modport master is the receiver side; slave is the codec/consumer side.
interface adc_tdm_rx_if;
    logic               sdout;
    logic               bick;
    logic               lrck;
    logic               sample_clk;
    logic signed [15:0] adc_in0;
    logic signed [15:0] adc_in1;
    logic signed [15:0] adc_in2;
    logic signed [15:0] adc_in3;
    logic               sample_valid;

    modport master (
        input  sdout,
        output bick, lrck, sample_clk,
        output adc_in0, adc_in1, adc_in2, adc_in3,
        output sample_valid
    );

    modport slave (
        output sdout,
        input  bick, lrck, sample_clk,
        input  adc_in0, adc_in1, adc_in2, adc_in3,
        input  sample_valid
    );
endinterface

// File: rtl/adc_tdm_rx.sv
// adc_tdm_rx
// TDM128 receiver for a 4-channel audio ADC. Generates BICK and LRCK from the
// system clock, deserialises 16-bit MSB-first words from the first 16 bits of
// each 32-bit slot and presents all four channels once per frame.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : adc_tdm_rx_if.master (sdout in; bick, lrck, sample_clk,
//           adc_in0..3, sample_valid out)
// Parameter BICK_DIV (1..255): clk cycles per BICK half-period.
module adc_tdm_rx #(
    parameter int BICK_DIV = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    adc_tdm_rx_if.master  bus
);
    localparam int DATA_W = 16;
    localparam int DIV_W  = 8;

    logic [DIV_W-1:0]         div_cnt;
    logic                     bick_r;
    logic                     lrck_r;
    logic [6:0]               bit_cnt;
    logic [6:0]               bit_nxt;
    logic                     frame_ok;
    logic [DATA_W-1:0]        shift_p0;
    logic [DATA_W-1:0]        shift_in;
    logic signed [DATA_W-1:0] hold_p0 [4];
    logic signed [DATA_W-1:0] adc_p1  [4];
    logic                     vld_p1;

    logic       div_wrap;
    logic       rise_tick;
    logic       fall_tick;
    logic [1:0] slot;
    logic [4:0] pos;
    logic       in_word;

    assign div_wrap  = (div_cnt == DIV_W'(BICK_DIV - 1));
    assign rise_tick = div_wrap & ~bick_r;
    assign fall_tick = div_wrap &  bick_r;
    assign bit_nxt   = bit_cnt + 7'd1;
    assign slot      = bit_cnt[6:5];
    assign pos       = bit_cnt[4:0];
    assign in_word   = (pos != 5'd0) && (pos <= 5'd16);
    assign shift_in  = {shift_p0[DATA_W-2:0], bus.sdout};

    // Clock generation: BICK toggles on divider wrap; bit counter and LRCK
    // advance together on the BICK falling toggle. frame_ok marks that a
    // complete frame has started since reset, so the bit_cnt=127 position
    // left by reset never publishes a partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            bick_r   <= 1'b0;
            lrck_r   <= 1'b0;
            bit_cnt  <= 7'd127;
            frame_ok <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                bick_r  <= ~bick_r;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall_tick) begin
                bit_cnt <= bit_nxt;
                lrck_r  <= ~bit_nxt[6];
                if (bit_cnt == 7'd127) frame_ok <= 1'b1;
            end
        end
    end

    // Stage p0: sdout captured on the BICK rising toggle; completed words
    // land in the per-slot hold registers at p=16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_p0 <= '0;
            for (int i = 0; i < 4; i++) hold_p0[i] <= '0;
        end else if (rise_tick) begin
            if (in_word) shift_p0 <= shift_in;
            if (pos == 5'd16) hold_p0[slot] <= $signed(shift_in);
        end
    end

    // Stage p1: all four channels published together at the last bit of the
    // frame, ahead of the next LRCK rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) adc_p1[i] <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (rise_tick && (bit_cnt == 7'd127) && frame_ok) begin
                adc_p1 <= hold_p0;
                vld_p1 <= 1'b1;
            end
        end
    end

    assign bus.bick         = bick_r;
    assign bus.lrck         = lrck_r;
    assign bus.sample_clk   = lrck_r;
    assign bus.adc_in0      = adc_p1[0];
    assign bus.adc_in1      = adc_p1[1];
    assign bus.adc_in2      = adc_p1[2];
    assign bus.adc_in3      = adc_p1[3];
    assign bus.sample_valid = vld_p1;
endmodule
